wb_arbiter: RTL

Three-master to one-slave Wishbone round-robin arbiter. Allows several bus masters to share a single slave port, for example two CPU ports plus a DMA engine feeding the slave side of the address-decoding switch. It holds the grant for a master's entire cycle (`cyc` high), so multi-beat and read-modify-write tenures stay atomic. It rotates priority after each tenure.

---
 rtl/wb_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Three-master to one-slave Wishbone round-robin arbiter; the grant is held for a whole cyc tenure.
// Optional stall timeout built when WB_ARB_TIMEOUT_EN is defined (TIMEOUT sets the stall limit).
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  input  logic [31:0] m2_dat_i,
  input  logic [31:0] m2_adr_i,
  input  logic [3:0]  m2_sel_i,
  input  logic        m2_we_i,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  pick;
  logic [2:0]  cyc_vec;
  logic        g_cyc, g_stb, g_we;
  logic [31:0] g_dat, g_adr;
  logic [3:0]  g_sel;
  logic        active;
  logic        to_hit;
  logic        ack_any;

  assign cyc_vec = {m2_cyc_i, m1_cyc_i, m0_cyc_i};

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_dat = '0;
    g_adr = '0;
    g_sel = '0;
    case (gnt_q)
      2'd0: begin
        g_cyc = m0_cyc_i; g_stb = m0_stb_i; g_we = m0_we_i;
        g_dat = m0_dat_i; g_adr = m0_adr_i; g_sel = m0_sel_i;
      end
      2'd1: begin
        g_cyc = m1_cyc_i; g_stb = m1_stb_i; g_we = m1_we_i;
        g_dat = m1_dat_i; g_adr = m1_adr_i; g_sel = m1_sel_i;
      end
      2'd2: begin
        g_cyc = m2_cyc_i; g_stb = m2_stb_i; g_we = m2_we_i;
        g_dat = m2_dat_i; g_adr = m2_adr_i; g_sel = m2_sel_i;
      end
      default: ;
    endcase
  end

  // Rotating search starting just after the last granted master.
  always_comb begin
    pick = 2'd0;
    case (last_q)
      2'd0:    pick = m1_cyc_i ? 2'd1 : (m2_cyc_i ? 2'd2 : 2'd0);
      2'd1:    pick = m2_cyc_i ? 2'd2 : (m0_cyc_i ? 2'd0 : 2'd1);
      default: pick = m0_cyc_i ? 2'd0 : (m1_cyc_i ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|cyc_vec) begin
          state_d = GNT;
          gnt_d   = pick;
        end
      end
      GNT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = gnt_q;
          gnt_d   = 2'd3;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'd3;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign active = (state_q == GNT) && !wb_rst_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;

  assign to_hit = active && (stall_q == 8'(TIMEOUT));

  always_comb begin
    stall_d = stall_q;
    if (state_q != GNT || !g_cyc || s_ack_i || to_hit) begin
      stall_d = '0;
    end else if (g_stb) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign to_hit         = 1'b0;
`endif

  assign ack_any = active && (s_ack_i || to_hit);

  assign s_cyc_o = active && g_cyc;
  assign s_stb_o = active && g_stb && !to_hit;
  assign s_we_o  = active && g_we;
  assign s_dat_o = active ? g_dat : '0;
  assign s_adr_o = active ? g_adr : '0;
  assign s_sel_o = active ? g_sel : '0;

  assign m0_ack_o = ack_any && (gnt_q == 2'd0);
  assign m1_ack_o = ack_any && (gnt_q == 2'd1);
  assign m2_ack_o = ack_any && (gnt_q == 2'd2);

  assign m0_dat_o = (to_hit && gnt_q == 2'd0) ? '1 : s_dat_i;
  assign m1_dat_o = (to_hit && gnt_q == 2'd1) ? '1 : s_dat_i;
  assign m2_dat_o = (to_hit && gnt_q == 2'd2) ? '1 : s_dat_i;

  assign gnt_o = gnt_q;

endmodule
